nibble_serial_adder: RTL

Sequential controller that adds two WIDTH-bit operands by reusing one 4-bit `fullAdder` datapath cell over WIDTH/4 consecutive cycles, least-significant nibble first. The carry is held in a register between nibbles. The block gives wide additions to the rest of the design without replicating adder cells, and it connects to producer and consumer logic through valid/ready handshakes.

---
 rtl/adder_pkg.sv | 17 +
 rtl/fullAdder.sv | 14 +
 rtl/nibble_serial_adder.sv | 117 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned NIB_W = 4;

   // Nibble counter width; a single-nibble operand still needs one counter bit.
   function automatic int unsigned cnt_width(input int unsigned nib);
      return (nib <= 1) ? 1 : $clog2(nib);
   endfunction

endpackage

// File: rtl/fullAdder.sv
// Existing 4-bit ripple adder cell, purely combinational.
module fullAdder
   import adder_pkg::*;
(
   input  logic [NIB_W-1:0] A,
   input  logic [NIB_W-1:0] B,
   input  logic             Cin,
   output logic [NIB_W-1:0] Sum,
   output logic             Cout
);

   assign {Cout, Sum} = (NIB_W+1)'(A) + (NIB_W+1)'(B) + (NIB_W+1)'(Cin);

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit cell over WIDTH/4 cycles, LS nibble first,
// with valid/ready handshakes on both sides and a synchronous abort.
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NIB  = WIDTH / NIB_W;
   localparam int unsigned CW   = cnt_width(NIB);
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_width_chk
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
   end

   state_e             state;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               carry_q;
   logic [CW-1:0]      idx;

   logic [NIB_W-1:0]   a_nib;
   logic [NIB_W-1:0]   b_nib;
   logic [NIB_W-1:0]   fa_sum;
   logic               fa_cout;
   logic               ovf_c;

   // Select the current operand nibbles for the shared cell.
   always_comb begin
      a_nib = a_q[NIB_W*idx +: NIB_W];
      b_nib = b_q[NIB_W*idx +: NIB_W];
      ovf_c = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (fa_sum[NIB_W-1] != a_q[WIDTH-1]);
   end

   fullAdder u_fa (
      .A    (a_nib),
      .B    (b_nib),
      .Cin  (carry_q),
      .Sum  (fa_sum),
      .Cout (fa_cout)
   );

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         carry_q   <= 1'b0;
         idx       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else if (abort) begin
         // Result outputs keep their last values on cancel.
         state     <= IDLE;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  carry_q  <= cin;
                  idx      <= '0;
                  sum      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
               end
            end
            RUN: begin
               sum[NIB_W*idx +: NIB_W] <= fa_sum;
               carry_q                 <= fa_cout;
               if (idx == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  cout      <= fa_cout;
                  ovf       <= ovf_c;
               end else begin
                  idx <= idx + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule
